score_board: RTL and testbench

SCORE_BOARD -- requirements
Module: score_board

---
 rtl/score_board_if.sv | 24 ++
 rtl/score_board.sv | 222 ++++++++++++++++++++++
 tb/tb_score_board.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_board_if.sv
// Display-stage <-> score_board bus.
//   master : display stage / bench; drives vs, lose, bounce, start_n
//   slave  : score_board; drives HEX0..HEX3 (active-low segments, bit0=a) and game_over
interface score_board_if;
  logic       vs;
  logic       lose;
  logic       bounce;
  logic       start_n;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic       game_over;

  modport master (
    output vs, lose, bounce, start_n,
    input  HEX0, HEX1, HEX2, HEX3, game_over
  );

  modport slave (
    input  vs, lose, bounce, start_n,
    output HEX0, HEX1, HEX2, HEX3, game_over
  );
endinterface

// File: rtl/score_board.sv
// score_board: score / lives keeper for a paddle game with 7-segment readout.
//   clk  : 50 MHz system clock
//   rst  : asynchronous active-low reset
//   bus  : score_board_if.slave
//          in  vs (frame sync, active-low), lose, bounce (levels), start_n (key)
//          out HEX0 = score ones, HEX1 = score tens, HEX2 = blank, HEX3 = lives,
//              game_over = high while in OVER
// Optional feature macro: SCORE_BLINK_EN -- blinks the display in OVER, one
// half-period every BLINK_FRAMES frames. Without it vs is unused.
module score_board #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic          clk,
  input logic          rst,
  score_board_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [3:0] LIVES_BCD = 4'(LIVES);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low 7-segment glyphs; anything outside 0-9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Synchronizers: [0],[1] = 2-flop sync, [2] = history for edge detection.
  logic [2:0] lose_sr_q;
  logic [2:0] bounce_sr_q;
  logic [2:0] start_sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lose_sr_q   <= 3'b000;
      bounce_sr_q <= 3'b000;
      start_sr_q  <= 3'b111;
    end else begin
      lose_sr_q   <= {lose_sr_q[1:0], bus.lose};
      bounce_sr_q <= {bounce_sr_q[1:0], bus.bounce};
      start_sr_q  <= {start_sr_q[1:0], bus.start_n};
    end
  end

  logic miss;
  logic hit;
  logic start;

  assign miss  = lose_sr_q[1] & ~lose_sr_q[2];
  assign hit   = bounce_sr_q[1] & ~bounce_sr_q[2];
  assign start = ~start_sr_q[1] & start_sr_q[2];

  // Game state: FSM, BCD score, lives.
  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] lives_q, lives_d;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    lives_d = lives_q;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          lives_d = LIVES_BCD;
        end
      end
      PLAY: begin
        // hit and miss in the same cycle both apply, even on the final miss.
        if (hit) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
        if (miss && (lives_q != 4'd0)) begin
          lives_d = lives_q - 4'd1;
          if (lives_q == 4'd1) begin
            state_d = OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      lives_q <= LIVES_BCD;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      lives_q <= lives_d;
    end
  end

  // Blink phase: high = digits shown.
  logic blink_on;

`ifdef SCORE_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic [2:0]       vs_sr_q;
  logic             frame;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sr_q <= 3'b111;
    end else begin
      vs_sr_q <= {vs_sr_q[1:0], bus.vs};
    end
  end

  assign frame = ~vs_sr_q[1] & vs_sr_q[2];

  // Counter is cleared the same edge OVER is left, so PLAY never shows a blank.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (state_d != OVER) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if ((state_q == OVER) && frame) begin
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blink_on = blink_on_q;
`else
  logic unused_vs;
  assign unused_vs = bus.vs;
  assign blink_on  = 1'b1;
`endif

  // Registered display and game_over, one cycle behind the counters.
  logic       blank;
  logic [6:0] hex0_q, hex0_d;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex2_q, hex2_d;
  logic [6:0] hex3_q, hex3_d;
  logic       game_over_q, game_over_d;

  always_comb begin
    blank       = (state_q == OVER) && !blink_on;
    hex0_d      = blank ? SEG_BLANK : seg7(ones_q);
    hex1_d      = blank ? SEG_BLANK : seg7(tens_q);
    hex2_d      = SEG_BLANK;
    hex3_d      = blank ? SEG_BLANK : seg7(lives_q);
    game_over_d = (state_q == OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hex0_q      <= seg7(4'd0);
      hex1_q      <= seg7(4'd0);
      hex2_q      <= SEG_BLANK;
      hex3_q      <= seg7(LIVES_BCD);
      game_over_q <= 1'b0;
    end else begin
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex2_q      <= hex2_d;
      hex3_q      <= hex3_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.HEX0      = hex0_q;
  assign bus.HEX1      = hex1_q;
  assign bus.HEX2      = hex2_q;
  assign bus.HEX3      = hex3_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_score_board.sv
// Bench for score_board: a game-rule model predicts every output each cycle,
// directed scenarios add literal expectations on DUT and model.
module tb_score_board;

  localparam int LIVES        = 3;
  localparam int BLINK_FRAMES = 30;
  localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  score_board_if bus ();

  score_board #(.LIVES(LIVES), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  logic [6:0] glyph_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] glyph(input int v);
    if (v < 0 || v > 9) return 7'h7F;
    return glyph_tbl[v];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  // Events are input edges seen two clocks after first sampling; displayed
  // values are the game values as they stood one clock earlier.
  int         m_state, m_score, m_lives, m_fcnt;
  bit         m_phase;
  bit         h_vs[0:3], h_lose[0:3], h_bounce[0:3], h_start[0:3];
  logic [6:0] e_hex0, e_hex1, e_hex2, e_hex3;
  logic       e_go;

  task automatic m_reset();
    m_state = S_IDLE; m_score = 0; m_lives = LIVES; m_fcnt = 0; m_phase = 1'b1;
    for (int i = 0; i < 4; i++) begin
      h_vs[i] = 1'b1; h_start[i] = 1'b1; h_lose[i] = 1'b0; h_bounce[i] = 1'b0;
    end
    e_hex0 = glyph(0); e_hex1 = glyph(0); e_hex2 = 7'h7F; e_hex3 = glyph(LIVES); e_go = 1'b0;
  endtask

  task automatic m_step();
    bit blank, hit, miss, start, frame;
    int pre;
    blank  = (m_state == S_OVER) && !m_phase;
    e_hex0 = blank ? 7'h7F : glyph(m_score % 10);
    e_hex1 = blank ? 7'h7F : glyph(m_score / 10);
    e_hex2 = 7'h7F;
    e_hex3 = blank ? 7'h7F : glyph(m_lives);
    e_go   = (m_state == S_OVER);
    for (int i = 3; i > 0; i--) begin
      h_vs[i] = h_vs[i-1]; h_lose[i] = h_lose[i-1];
      h_bounce[i] = h_bounce[i-1]; h_start[i] = h_start[i-1];
    end
    h_vs[0] = bus.vs; h_lose[0] = bus.lose; h_bounce[0] = bus.bounce; h_start[0] = bus.start_n;
    hit   = h_bounce[2] && !h_bounce[3];
    miss  = h_lose[2] && !h_lose[3];
    start = !h_start[2] && h_start[3];
    frame = !h_vs[2] && h_vs[3];
    pre   = m_state;
    if (m_state == S_PLAY) begin
      if (hit) m_score = (m_score + 1) % 100;
      if (miss) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_state = S_OVER;
      end
    end else if (start) begin
      m_state = S_PLAY; m_score = 0; m_lives = LIVES;
    end
`ifdef SCORE_BLINK_EN
    if (m_state != S_OVER) begin
      m_fcnt = 0; m_phase = 1'b1;
    end else if (pre == S_OVER && frame) begin
      m_fcnt = m_fcnt + 1;
      if (m_fcnt == BLINK_FRAMES) begin
        m_fcnt = 0; m_phase = !m_phase;
      end
    end
`else
    if (frame && pre < 0) m_fcnt = 0;
`endif
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else m_step();
    end
  end

  // Compare process: outputs are registered and meaningful every cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_hex0", bus.HEX0, e_hex0);
      chk("cyc_hex1", bus.HEX1, e_hex1);
      chk("cyc_hex2", bus.HEX2, e_hex2);
      chk("cyc_hex3", bus.HEX3, e_hex3);
      chk("cyc_game_over", bus.game_over, e_go);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bounces(input int n);
    repeat (n) begin
      bus.bounce = 1'b1; cyc(4);
      bus.bounce = 1'b0; cyc(4);
    end
  endtask

  task automatic loses(input int n);
    repeat (n) begin
      bus.lose = 1'b1; cyc(4);
      bus.lose = 1'b0; cyc(4);
    end
  endtask

  task automatic press_start();
    bus.start_n = 1'b0; cyc(4);
    bus.start_n = 1'b1; cyc(6);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.vs = 1'b0; cyc(4);
      bus.vs = 1'b1; cyc(4);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hex0"}, bus.HEX0, 7'h40);
    chk({tag, "_hex1"}, bus.HEX1, 7'h40);
    chk({tag, "_hex2"}, bus.HEX2, 7'h7F);
    chk({tag, "_hex3"}, bus.HEX3, 7'h30);
    chk({tag, "_go"}, bus.game_over, 1'b0);
  endtask

  initial begin
    bus.vs = 1'b1; bus.lose = 1'b0; bus.bounce = 1'b0; bus.start_n = 1'b1;
    cyc(3);
    chk_reset_vals("reset");
    rst = 1'b1;
    cyc(3);

    // hits in IDLE are ignored
    bounces(2);
    chk("idle_hit_ignored", bus.HEX0, 7'h40);

    press_start();
    chk("start_model_state", m_state, S_PLAY);
    chk("start_hex0", bus.HEX0, 7'h40);
    chk("start_hex1", bus.HEX1, 7'h40);
    chk("start_hex3", bus.HEX3, 7'h30);

    bounces(12);
    chk("score12_hex1", bus.HEX1, 7'h79);
    chk("score12_hex0", bus.HEX0, 7'h24);
    chk("score12_go", bus.game_over, 1'b0);
    chk("score12_model", m_score, 12);

    // start ignored in PLAY
    press_start();
    chk("play_start_ignored", bus.HEX0, 7'h24);

    bounces(87);
    chk("score99_hex1", bus.HEX1, 7'h10);
    chk("score99_hex0", bus.HEX0, 7'h10);
    bounces(1);
    chk("wrap_hex1", bus.HEX1, 7'h40);
    chk("wrap_hex0", bus.HEX0, 7'h40);
    chk("wrap_hex3", bus.HEX3, 7'h30);

    loses(2);
    chk("lives1_hex3", bus.HEX3, 7'h79);
    chk("lives1_go", bus.game_over, 1'b0);

    // third miss: first sampled at edge N, game_over appears after edge N+3
    bus.lose = 1'b1;
    cyc(3);
    chk("miss3_n2_go", bus.game_over, 1'b0);
    cyc(1);
    chk("miss3_n3_go", bus.game_over, 1'b1);
    chk("miss3_n3_hex3", bus.HEX3, 7'h40);
    bus.lose = 1'b0; cyc(4);

    bounces(3);
    chk("over_frozen_hex0", bus.HEX0, 7'h40);
    chk("over_model_state", m_state, S_OVER);

    press_start();
    chk("restart_hex3", bus.HEX3, 7'h30);
    chk("restart_go", bus.game_over, 1'b0);
    loses(2);

    // simultaneous hit and final miss
    bus.bounce = 1'b1; bus.lose = 1'b1; cyc(4);
    bus.bounce = 1'b0; bus.lose = 1'b0; cyc(4);
    chk("both_hex0", bus.HEX0, 7'h79);
    chk("both_hex3", bus.HEX3, 7'h40);
    chk("both_go", bus.game_over, 1'b1);
    chk("both_model_score", m_score, 1);

    frames(BLINK_FRAMES);
`ifdef SCORE_BLINK_EN
    chk("blink_off_hex0", bus.HEX0, 7'h7F);
    chk("blink_off_hex1", bus.HEX1, 7'h7F);
    chk("blink_off_hex3", bus.HEX3, 7'h7F);
`else
    chk("steady_hex0", bus.HEX0, 7'h79);
    chk("steady_hex3", bus.HEX3, 7'h40);
`endif
    frames(BLINK_FRAMES);
    chk("blink_on_hex0", bus.HEX0, 7'h79);
    chk("blink_on_hex3", bus.HEX3, 7'h40);
`ifdef SCORE_BLINK_EN
    frames(BLINK_FRAMES);
    chk("blink_off2_hex0", bus.HEX0, 7'h7F);
`endif
    press_start();
    chk("blink_exit_hex0", bus.HEX0, 7'h40);
    chk("blink_exit_hex3", bus.HEX3, 7'h30);
    chk("blink_exit_go", bus.game_over, 1'b0);

    // mid-game reset with a hit in flight
    bounces(3);
    chk("pre_reset_hex0", bus.HEX0, 7'h30);
    bus.bounce = 1'b1;
    @(posedge clk);
    #5 rst = 1'b0;
    #1 chk_reset_vals("midreset");
    cyc(1);
    bus.bounce = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(4);
    chk("post_reset_state", m_state, S_IDLE);
    chk_reset_vals("post_reset");
    press_start();
    chk("post_reset_play_hex0", bus.HEX0, 7'h40);
    chk("post_reset_play_hex3", bus.HEX3, 7'h30);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
